// File: rtl/bcd_conv_sched_if.sv
// bcd_conv_sched_if: channel, converter and result signals of the shared BCD converter scheduler
interface bcd_conv_sched_if #(parameter int N = 3);
  logic [8*N-1:0]  bin_in;
  logic [N-1:0]    req;
  logic            tick;
  logic            conv_start;
  logic [7:0]      conv_bin;
  logic [3:0]      conv_one;
  logic [3:0]      conv_ten;
  logic [1:0]      conv_hun;
  logic [10*N-1:0] bcd_out;
  logic [N-1:0]    valid;
  logic            done;
  logic [2:0]      done_ch;
  logic            busy;
  modport slave (
    input  bin_in, req, tick, conv_one, conv_ten, conv_hun,
    output conv_start, conv_bin, bcd_out, valid, done, done_ch, busy
  );
  modport master (
    output bin_in, req, tick, conv_one, conv_ten, conv_hun,
    input  conv_start, conv_bin, bcd_out, valid, done, done_ch, busy
  );
endinterface

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: round-robin sharing of one start-pulse binary-to-BCD converter between N channels
module bcd_conv_sched #(
  parameter int N        = 3,
  parameter int CONV_LAT = 11,
  parameter int CW       = 4
) (
  input logic             clk,
  input logic             rst_n,
  bcd_conv_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT, CAPTURE} state_t;
  state_t          state_q, state_d;
  logic [N-1:0]    pend_q, pend_d, valid_q, valid_d;
  logic [2:0]      ptr_q, ptr_d, grant_q, grant_d, done_ch_q, done_ch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      bin_q, bin_d;
  logic [10*N-1:0] bcd_q, bcd_d;
  logic            done_q, done_d;
  logic [2:0]      pick;
  logic            found;
  int              j;
  // lowest offset from ptr wins, so scan offsets from the top down
  always_comb begin
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int i = N-1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      j = (j >= N) ? j - N : j;
      if (pend_q[j]) begin
        pick  = 3'(j);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    done_ch_d = done_ch_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        grant_d = pick;
        bin_d   = bus.bin_in[int'(pick)*8 +: 8];
        state_d = START;
      end
      START: begin
        pend_d[int'(grant_q)] = 1'b0;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(CONV_LAT-1)) ? CAPTURE : WAIT;
      end
      CAPTURE: begin
        bcd_d[int'(grant_q)*10 +: 10] = {bus.conv_hun, bus.conv_ten, bus.conv_one};
        valid_d[int'(grant_q)] = 1'b1;
        ptr_d     = (grant_q == 3'(N-1)) ? 3'd0 : grant_q + 3'd1;
        done_d    = 1'b1;
        done_ch_d = grant_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pend_d = pend_d | bus.req | {N{bus.tick}};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      valid_q   <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      done_ch_q <= '0;
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      valid_q   <= valid_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      done_ch_q <= done_ch_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end
  assign bus.conv_start = (state_q == START);
  assign bus.busy       = (state_q != IDLE);
  assign bus.conv_bin   = bin_q;
  assign bus.bcd_out    = bcd_q;
  assign bus.valid      = valid_q;
  assign bus.done       = done_q;
  assign bus.done_ch    = done_ch_q;
endmodule
